mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the pipeline's single unified memory port between the instruction-fetch stage and the data (MEM) stage of the five-stage RISC-V core. Each requester issues a hold-until-ready request. The arbiter grants one at a time, drives the shared port, waits for the memory acknowledge, and returns registered read data with a one-cycle ready pulse. It sits between the core's IF/MEM stage interfaces and the memory model in `top`, and its ready signals feed the core's stall logic.

## Interface
- `AW`, 32: address width
- `DW`, 32: data width; byte-enable width is DW/8
- `STREAK_MAX`, 4: consecutive data grants allowed while fetch waits (1..15)
- `TIMEOUT`, 16: watchdog limit in cycles, used only with the config macro (2..255)

- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `if_req` in 1: fetch request, held until `if_ready`
- `if_addr` in AW: fetch address
- `if_rdata` out DW: fetched instruction, valid while `if_ready`=1
- `if_ready` out 1: one-cycle completion pulse
- `d_req` in 1: data request, held until `d_ready`
- `d_we` in 1: 1 = store, 0 = load
- `d_addr` in AW: data address
- `d_wdata` in DW: store data
- `d_be` in DW/8: store byte enables
- `d_rdata` out DW: load data, valid while `d_ready`=1
- `d_ready` out 1: one-cycle completion pulse
- `m_req` out 1: memory request, held until `m_ack`
- `m_we`, `m_addr`, `m_wdata`, `m_be` out 1/AW/DW/DW/8: registered copy of the granted request
- `m_rdata` in DW: memory read data, valid with `m_ack`
- `m_ack` in 1: one-cycle transaction-complete strobe
- `busy` out 1: 1 in any state other than IDLE
- `err` out 1: watchdog abort flag, valid with ready (config only; tied 0 otherwise)

## Operation
- FSM states: IDLE, IF_ACC, D_ACC, RESP.
- IDLE, arbitration:
  - `d_req` alone: go to D_ACC.
  - `if_req` alone: go to IF_ACC.
  - Both asserted: data wins, unless `streak` equals STREAK_MAX, in which case fetch wins.
  - Latch the grant owner and all request fields into the `m_*` registers.
- `streak` (4-bit):
  - Increments on each data grant made while `if_req`=1.
  - Clears on any fetch grant, and on any data grant made while `if_req`=0.
  - Saturates at STREAK_MAX.
- IF_ACC / D_ACC:
  - `m_req`=1 with stable `m_*` fields.
  - On `m_ack`: capture `m_rdata` into the owner's rdata register, drop `m_req`, go to RESP.
- RESP: pulse the owner's ready for one cycle, then go to IDLE.
  - For a store, the owner's rdata holds its previous value and is don't-care.
- The arbiter never modifies requester data. `m_wdata` and `m_be` are meaningful only when `m_we`=1. Fetch grants drive `m_we`=0 and `m_be`=all ones.
- A request dropped before its ready arrives is a protocol violation. The arbiter completes the access anyway and still pulses ready.
- `m_ack` outside IF_ACC/D_ACC is ignored.

## Timing
- Reset values: all outputs 0, all `*_rdata` 0, state IDLE, `streak` 0.
- Reset assertion mid-access abandons the memory transaction immediately.
- Minimum access sequence, from request seen in IDLE at cycle 0:
  - `m_req` high at cycle 1.
  - `m_ack` no earlier than cycle 1.
  - Ready at the cycle after `m_ack`.
  - IDLE the cycle after that, where a new request may be sampled.
- Single-cycle memory: 3 cycles per access. Back-to-back throughput is one access every 3 cycles.
- Memory wait states add one cycle each to the ACC state.
- Requesters sample ready at the clock edge and may change or drop req in the following cycle (the IDLE cycle).

## Configuration
- `MEM_PORT_ARB_TIMEOUT_EN` defined:
  - An 8-bit watchdog counts cycles in IF_ACC/D_ACC.
  - At TIMEOUT cycles without `m_ack`: drop `m_req`, set rdata to 0, go to RESP with `err`=1 for the ready cycle.
  - A late `m_ack` is then ignored.
- Macro undefined: no watchdog; ACC waits indefinitely; `err` is constant 0.

## Structure
- Shared package holds the state-encoding constants (IDLE=2'd0, IF_ACC=2'd1, D_ACC=2'd2, RESP=2'd3) and the owner codes (OWN_IF=1'b0, OWN_D=1'b1).
- One sub-module, `arb_grant_sel`: combinational priority and anti-starvation decision from `if_req`, `d_req`, and `streak`.
- FSM, registers, and watchdog live in the top module.

## Test plan
- Fetch only, `if_addr`=0x00000004, memory returns 0x00000113 with 0 wait states:
  - `m_req` at cycle 1, `if_ready` at cycle 2 with `if_rdata`=0x00000113.
  - `busy` low at cycle 3.
- Store, `d_we`=1, `d_addr`=0x100, `d_wdata`=0xFFFFF002, `d_be`=0xF, 2 wait states:
  - `m_we`=1 and `m_addr`=0x100 held 3 cycles, then `d_ready` pulses once.
- Fetch and data requesting continuously, STREAK_MAX=4:
  - Grant order D,D,D,D,IF,D,D,D,D,IF.
  - `streak` never exceeds 4.
- Reset deasserted to 0 while in D_ACC with `m_req`=1:
  - All outputs 0 within the same cycle.
  - After release, IDLE and a fresh fetch completes normally.
- Stray `m_ack` in IDLE: no ready pulse, no state change.
- With `MEM_PORT_ARB_TIMEOUT_EN`, TIMEOUT=16, memory never acks:
  - `m_req` drops after 16 cycles.
  - `d_ready`=1, `err`=1, `d_rdata`=0.
  - A `m_ack` arriving at cycle 20 is ignored.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory-port arbiter: FSM state
// encoding, grant-owner codes and counter widths.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    D_ACC  = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  // Width of the consecutive-data-grant counter and of the watchdog.
  localparam int STREAK_W = 4;
  localparam int WDOG_W   = 8;

endpackage

// File: rtl/arb_grant_sel.sv
// Combinational grant decision for the memory-port arbiter. Data has
// priority over fetch, except when data has already won STREAK_MAX
// consecutive contested grants, in which case fetch is served.
module arb_grant_sel
  import mem_port_arbiter_pkg::*;
#(
  parameter int STREAK_MAX = 4
) (
  input  logic                if_req_i,
  input  logic                d_req_i,
  input  logic [STREAK_W-1:0] streak_i,
  output logic                grant_o,
  output logic                owner_o
);

  localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(STREAK_MAX);

  // Pick the owner of the next grant; fetch wins only when starved.
  always_comb begin
    grant_o = if_req_i | d_req_i;
    owner_o = OWN_IF;
    if (d_req_i && !(if_req_i && (streak_i == STREAK_LIM))) begin
      owner_o = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter for the core's single unified memory port, shared between the
// instruction-fetch and data stages. One access at a time: grant, hold
// the port until m_ack, then a one-cycle registered ready pulse.
// Optional watchdog abort: define MEM_PORT_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STREAK_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_ready,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic [DW-1:0]   d_rdata,
  output logic            d_ready,
  output logic            m_req,
  output logic            m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_be,
  input  logic [DW-1:0]   m_rdata,
  input  logic            m_ack,
  output logic            busy,
  output logic            err
);

  localparam int BW = DW / 8;
  localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(STREAK_MAX);

  // Elaboration-time parameter range checks.
  if (STREAK_MAX < 1 || STREAK_MAX > 15) begin : g_bad_streak
    $error("mem_port_arbiter: STREAK_MAX must be 1..15");
  end
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT must be 2..255");
  end

  state_e                state_q;
  logic                  m_req_q;
  logic                  m_we_q;
  logic [AW-1:0]         m_addr_q;
  logic [DW-1:0]         m_wdata_q;
  logic [BW-1:0]         m_be_q;
  logic [DW-1:0]         if_rdata_q;
  logic [DW-1:0]         d_rdata_q;
  logic                  if_ready_q;
  logic                  d_ready_q;
  logic                  busy_q;
  logic [STREAK_W-1:0]   streak_q;
  logic [STREAK_W-1:0]   streak_d;
  logic                  grant_vld;
  logic                  grant_own;

  arb_grant_sel #(
    .STREAK_MAX (STREAK_MAX)
  ) u_grant_sel (
    .if_req_i (if_req),
    .d_req_i  (d_req),
    .streak_i (streak_q),
    .grant_o  (grant_vld),
    .owner_o  (grant_own)
  );

  // Next streak value if a grant is made this cycle: only contested data
  // grants extend the streak; it saturates at the limit.
  always_comb begin
    streak_d = '0;
    if (grant_own == OWN_D && if_req) begin
      streak_d = (streak_q == STREAK_LIM) ? streak_q : streak_q + 4'd1;
    end
  end

`ifdef MEM_PORT_ARB_TIMEOUT_EN
  localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(TIMEOUT - 1);
  logic [WDOG_W-1:0] wdog_q;
  logic              err_q;
`endif

  // Access FSM with all port-facing outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_be_q     <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
      streak_q   <= '0;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
      wdog_q     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            m_req_q  <= 1'b1;
            busy_q   <= 1'b1;
            streak_q <= streak_d;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
            wdog_q   <= '0;
`endif
            if (grant_own == OWN_D) begin
              state_q   <= D_ACC;
              m_we_q    <= d_we;
              m_addr_q  <= d_addr;
              m_wdata_q <= d_wdata;
              m_be_q    <= d_be;
            end else begin
              state_q   <= IF_ACC;
              m_we_q    <= 1'b0;
              m_addr_q  <= if_addr;
              m_wdata_q <= '0;
              m_be_q    <= '1;
            end
          end
        end
        IF_ACC, D_ACC: begin
          if (m_ack) begin
            m_req_q <= 1'b0;
            state_q <= RESP;
            if (state_q == D_ACC) begin
              d_ready_q <= 1'b1;
              // Stores leave the load-data register untouched.
              if (!m_we_q) d_rdata_q <= m_rdata;
            end else begin
              if_ready_q <= 1'b1;
              if_rdata_q <= m_rdata;
            end
          end
`ifdef MEM_PORT_ARB_TIMEOUT_EN
          else if (wdog_q == WDOG_LIM) begin
            // Memory never answered: abort and report with zero data.
            m_req_q <= 1'b0;
            state_q <= RESP;
            err_q   <= 1'b1;
            if (state_q == D_ACC) begin
              d_ready_q <= 1'b1;
              d_rdata_q <= '0;
            end else begin
              if_ready_q <= 1'b1;
              if_rdata_q <= '0;
            end
          end else begin
            wdog_q <= wdog_q + 8'd1;
          end
`endif
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign m_be     = m_be_q;
  assign if_rdata = if_rdata_q;
  assign if_ready = if_ready_q;
  assign d_rdata  = d_rdata_q;
  assign d_ready  = d_ready_q;
  assign busy     = busy_q;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Directed scenarios plus a
// randomized run checked against a transaction-level reference model.
// The watchdog scenario is compiled in with MEM_PORT_ARB_TIMEOUT_EN.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int SMAX = 4;
  localparam int TMO  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [BW-1:0] d_be;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [BW-1:0] m_be;
  logic [DW-1:0] m_rdata;
  logic          m_ack;
  logic          busy;
  logic          err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW (AW), .DW (DW), .STREAK_MAX (SMAX), .TIMEOUT (TMO)
  ) dut (
    .clk (clk), .reset (reset),
    .if_req (if_req), .if_addr (if_addr), .if_rdata (if_rdata), .if_ready (if_ready),
    .d_req (d_req), .d_we (d_we), .d_addr (d_addr), .d_wdata (d_wdata), .d_be (d_be),
    .d_rdata (d_rdata), .d_ready (d_ready),
    .m_req (m_req), .m_we (m_we), .m_addr (m_addr), .m_wdata (m_wdata), .m_be (m_be),
    .m_rdata (m_rdata), .m_ack (m_ack),
    .busy (busy), .err (err)
  );

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish, expected finish before 500000");
    $fatal(1);
  end

  task automatic drive_idle();
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    m_rdata = '0; m_ack = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({m_req, m_we, if_ready, d_ready, busy, err} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 000000", {m_req, m_we, if_ready, d_ready, busy, err});
    end
    vectors++;
    if ({m_addr, m_wdata, m_be} !== '0) begin
      miscompares++;
      $display("FAIL reset_mport: got addr=%h wdata=%h be=%h expected all 0", m_addr, m_wdata, m_be);
    end
    vectors++;
    if ({if_rdata, d_rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_rdata: got if=%h d=%h expected 0", if_rdata, d_rdata);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h0000_0004;
    @(negedge clk);  // cycle 1
    vectors++;
    if ({m_req, m_we, busy, if_ready} !== 4'b1010 || m_addr !== 32'h4 || m_be !== 4'hF) begin
      miscompares++;
      $display("FAIL fetch_c1: got req/we/busy/rdy=%b addr=%h be=%h expected 1010 00000004 f",
               {m_req, m_we, busy, if_ready}, m_addr, m_be);
    end
    m_ack = 1'b1; m_rdata = 32'h0000_0113;
    @(negedge clk);  // cycle 2
    vectors++;
    if (if_ready !== 1'b1 || if_rdata !== 32'h113 || m_req !== 1'b0 || d_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_c2: got rdy=%b rdata=%h m_req=%b d_rdy=%b expected 1 00000113 0 0",
               if_ready, if_rdata, m_req, d_ready);
    end
    m_ack = 1'b0; if_req = 1'b0;
    @(negedge clk);  // cycle 3
    vectors++;
    if (busy !== 1'b0 || if_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_c3: got busy=%b rdy=%b expected 0 0", busy, if_ready);
    end
  endtask

  task automatic test_store();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hFFFF_F002; d_be = 4'hF;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      vectors++;
      if ({m_req, m_we} !== 2'b11 || m_addr !== 32'h100 || m_wdata !== 32'hFFFF_F002 ||
          m_be !== 4'hF || d_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL store_hold_c%0d: got req/we=%b addr=%h wdata=%h be=%h rdy=%b expected 11 00000100 fffff002 f 0",
                 k, {m_req, m_we}, m_addr, m_wdata, m_be, d_ready);
      end
      if (k == 3) begin
        m_ack = 1'b1; m_rdata = 32'hDEAD_BEEF;
      end
    end
    @(negedge clk);  // cycle 4
    vectors++;
    if (d_ready !== 1'b1 || d_rdata !== 32'h0 || if_ready !== 1'b0 || m_req !== 1'b0) begin
      miscompares++;
      $display("FAIL store_ready: got d_rdy=%b d_rdata=%h if_rdy=%b m_req=%b expected 1 00000000 0 0",
               d_ready, d_rdata, if_ready, m_req);
    end
    m_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    vectors++;
    if (d_ready !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL store_single_pulse: got rdy=%b busy=%b expected 0 0", d_ready, busy);
    end
  endtask

  task automatic test_stray_ack();
    m_ack = 1'b1; m_rdata = 32'h0000_55AA;
    @(negedge clk);
    m_ack = 1'b0;
    @(negedge clk);
    vectors++;
    if ({if_ready, d_ready, busy, m_req} !== 4'b0 || if_rdata !== 32'h113 || d_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL stray_ack: got rdy/busy/req=%b if_rdata=%h d_rdata=%h expected 0000 00000113 00000000",
               {if_ready, d_ready, busy, m_req}, if_rdata, d_rdata);
    end
  endtask

  task automatic test_reset_mid();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    @(negedge clk);
    vectors++;
    if (m_req !== 1'b1 || m_addr !== 32'h200) begin
      miscompares++;
      $display("FAIL rstmid_acc: got m_req=%b addr=%h expected 1 00000200", m_req, m_addr);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({m_req, busy, if_ready, d_ready, m_we, err} !== 6'b0 || m_addr !== '0 || if_rdata !== '0) begin
      miscompares++;
      $display("FAIL rstmid_clear: got ctrl=%b addr=%h if_rdata=%h expected 000000 0 0",
               {m_req, busy, if_ready, d_ready, m_we, err}, m_addr, if_rdata);
    end
    @(negedge clk);
    reset = 1'b1; d_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || m_req !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_idle: got busy=%b m_req=%b expected 0 0", busy, m_req);
    end
    if_req = 1'b1; if_addr = 32'h8;
    @(negedge clk);
    vectors++;
    if (m_req !== 1'b1 || m_addr !== 32'h8) begin
      miscompares++;
      $display("FAIL rstmid_fetch_req: got m_req=%b addr=%h expected 1 00000008", m_req, m_addr);
    end
    m_ack = 1'b1; m_rdata = 32'h00A0_0093;
    @(negedge clk);
    vectors++;
    if (if_ready !== 1'b1 || if_rdata !== 32'h00A0_0093) begin
      miscompares++;
      $display("FAIL rstmid_fetch_done: got rdy=%b rdata=%h expected 1 00a00093", if_ready, if_rdata);
    end
    m_ack = 1'b0; if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_streak();
    logic exp_d[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic got_d[$];
    int   got_c[$];
    drive_idle();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    if_req = 1'b1; if_addr = 32'h400;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    for (int c = 0; c < 60 && got_d.size() < 10; c++) begin
      @(negedge clk);
      if (m_req) begin
        got_d.push_back(m_addr == 32'h300);
        got_c.push_back(c);
        m_ack = 1'b1; m_rdata = 32'(c);
      end else begin
        m_ack = 1'b0;
      end
    end
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (got_d.size() != 10) begin
      miscompares++;
      $display("FAIL streak_count: got %0d grants expected 10", got_d.size());
    end
    for (int i = 0; i < got_d.size(); i++) begin
      vectors++;
      if (got_d[i] !== exp_d[i]) begin
        miscompares++;
        $display("FAIL streak_order[%0d]: got data=%b expected data=%b", i, got_d[i], exp_d[i]);
      end
      if (i > 0) begin
        vectors++;
        if (got_c[i] - got_c[i-1] != 3) begin
          miscompares++;
          $display("FAIL streak_spacing[%0d]: got %0d cycles expected 3", i, got_c[i] - got_c[i-1]);
        end
      end
    end
  endtask

  // Randomized requesters and memory with a transaction-level model:
  // phase 0 = port free, 1 = access outstanding, 2 = ready being returned.
  task automatic test_random(input int ncyc, input int p_if, input int p_d);
    int            phase = 0;
    int            mstreak = 0;
    int            waits = 0;
    logic          own_d = 1'b0;
    logic          e_we = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0;
    logic [BW-1:0] e_be = '0;
    logic [DW-1:0] e_if_rdata = '0;
    logic [DW-1:0] e_d_rdata = '0;
    int            errs;
    drive_idle();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      // Advance the model over the clock edge just passed, using the
      // input values that were held across it.
      if (phase == 0) begin
        if (if_req || d_req) begin
          own_d = d_req && !(if_req && mstreak == SMAX);
          if (own_d) begin
            e_we = d_we; e_addr = d_addr; e_wdata = d_wdata; e_be = d_be;
            mstreak = if_req ? ((mstreak < SMAX) ? mstreak + 1 : mstreak) : 0;
          end else begin
            e_we = 1'b0; e_addr = if_addr; e_be = '1;
            mstreak = 0;
          end
          waits = $urandom_range(0, 3);
          phase = 1;
        end
      end else if (phase == 1) begin
        if (m_ack) begin
          if (!own_d) e_if_rdata = m_rdata;
          else if (!e_we) e_d_rdata = m_rdata;
          phase = 2;
        end
      end else begin
        phase = 0;
      end

      errs = 0;
      vectors++;
      if (busy !== (phase != 0) || m_req !== (phase == 1) ||
          if_ready !== (phase == 2 && !own_d) || d_ready !== (phase == 2 && own_d) || err !== 1'b0) begin
        miscompares++;
        errs++;
        $display("FAIL rand_ctrl@%0d: got busy/m_req/if_rdy/d_rdy/err=%b%b%b%b%b expected %b%b%b%b0",
                 c, busy, m_req, if_ready, d_ready, err,
                 phase != 0, phase == 1, phase == 2 && !own_d, phase == 2 && own_d);
      end
      vectors++;
      if (if_rdata !== e_if_rdata || d_rdata !== e_d_rdata) begin
        miscompares++;
        errs++;
        $display("FAIL rand_rdata@%0d: got if=%h d=%h expected if=%h d=%h",
                 c, if_rdata, d_rdata, e_if_rdata, e_d_rdata);
      end
      if (phase == 1) begin
        vectors++;
        if (m_addr !== e_addr || m_we !== e_we || m_be !== e_be || (e_we && m_wdata !== e_wdata)) begin
          miscompares++;
          errs++;
          $display("FAIL rand_mport@%0d: got addr=%h we=%b be=%h wdata=%h expected addr=%h we=%b be=%h wdata=%h",
                   c, m_addr, m_we, m_be, m_wdata, e_addr, e_we, e_be, e_wdata);
        end
      end
      if (errs != 0 && miscompares > 20) begin
        $display("FAIL rand_abort: got %0d miscompares expected 0", miscompares);
        break;
      end

      // Requesters: release on ready, otherwise hold or issue new work.
      if (phase == 2) begin
        if (own_d) d_req = 1'b0;
        else if_req = 1'b0;
      end
      if (!if_req && $urandom_range(0, 99) < p_if) begin
        if_req = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_req && $urandom_range(0, 99) < p_d) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom;
        d_wdata = $urandom; d_be = 4'($urandom_range(0, 15));
      end

      // Memory: ack after the chosen wait count; occasional stray acks.
      if (phase == 1) begin
        if (waits == 0) begin
          m_ack = 1'b1; m_rdata = $urandom;
        end else begin
          waits--; m_ack = 1'b0;
        end
      end else begin
        m_ack = ($urandom_range(0, 9) == 0); m_rdata = $urandom;
      end
    end
    drive_idle();
    repeat (4) @(negedge clk);
  endtask

`ifdef MEM_PORT_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int bad = 0;
    drive_idle();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    @(negedge clk);
    m_ack = 1'b1; m_rdata = 32'hCAFE_0001;
    @(negedge clk);
    vectors++;
    if (d_ready !== 1'b1 || d_rdata !== 32'hCAFE_0001 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL tmo_preload: got rdy=%b rdata=%h err=%b expected 1 cafe0001 0", d_ready, d_rdata, err);
    end
    m_ack = 1'b0; d_req = 1'b0;
    @(negedge clk);
    d_req = 1'b1; d_addr = 32'h44;
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      if (m_req !== 1'b1 || d_ready !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL tmo_wait: got %0d cycles with m_req low or early ready expected 0", bad);
    end
    @(negedge clk);  // cycle 17
    vectors++;
    if (m_req !== 1'b0 || d_ready !== 1'b1 || err !== 1'b1 || d_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL tmo_abort: got m_req=%b rdy=%b err=%b rdata=%h expected 0 1 1 00000000",
               m_req, d_ready, err, d_rdata);
    end
    d_req = 1'b0;
    @(negedge clk);  // cycle 18
    vectors++;
    if (err !== 1'b0 || d_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL tmo_err_pulse: got err=%b rdy=%b expected 0 0", err, d_ready);
    end
    @(negedge clk);  // cycle 19
    @(negedge clk);  // cycle 20
    m_ack = 1'b1; m_rdata = 32'h1234_5678;
    @(negedge clk);  // cycle 21
    m_ack = 1'b0;
    vectors++;
    if ({d_ready, if_ready, busy, err} !== 4'b0 || d_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL tmo_late_ack: got rdy/busy/err=%b d_rdata=%h expected 0000 00000000",
               {d_ready, if_ready, busy, err}, d_rdata);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    reset = 1'b0;
    drive_idle();
    test_reset();
    test_fetch();
    test_store();
    test_stray_ack();
    test_reset_mid();
    test_streak();
    test_random(2000, 60, 60);
    test_random(600, 100, 100);
`ifdef MEM_PORT_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
